// File: rtl/paralelo_serie.sv
// Parallel-to-serial transmitter: valid/ready word intake into a one-deep
// holding buffer, then one bit per shift_en strobe with gapless back-to-back words.
module paralelo_serie #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               hold_valid;
    logic               hold_valid_nxt;
    logic [WIDTH-1:0]   hold_reg;
    logic [WIDTH-1:0]   hold_reg_nxt;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shift_reg_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_nxt;
    logic               serial_nxt;
    logic               done_nxt;

    // Bit presented on the line for a given shift register content
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold_reg   <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            serial_out <= IDLE_LEVEL;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_valid <= hold_valid_nxt;
            hold_reg   <= hold_reg_nxt;
            shift_reg  <= shift_reg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            serial_out <= serial_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state: buffer intake, word transfer, bit advance
    always_comb begin
        state_nxt      = state;
        hold_valid_nxt = hold_valid;
        hold_reg_nxt   = hold_reg;
        shift_reg_nxt  = shift_reg;
        bit_cnt_nxt    = bit_cnt;
        done_nxt       = 1'b0;

        // Intake and transfer never coincide: intake needs an empty buffer
        if (load_valid && !hold_valid) begin
            hold_reg_nxt   = parallel_in;
            hold_valid_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    shift_reg_nxt  = hold_reg;
                    hold_valid_nxt = 1'b0;
                    bit_cnt_nxt    = '0;
                    state_nxt      = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (bit_cnt == LAST_BIT) begin
                        done_nxt = 1'b1;
                        if (hold_valid) begin
                            shift_reg_nxt  = hold_reg;
                            hold_valid_nxt = 1'b0;
                            bit_cnt_nxt    = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        shift_reg_nxt = shifted(shift_reg);
                        bit_cnt_nxt   = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        serial_nxt = (state_nxt == SHIFT) ? out_bit(shift_reg_nxt) : IDLE_LEVEL;
    end

    assign load_ready = !hold_valid;
    assign frame      = (state == SHIFT);
    assign busy       = (state == SHIFT) || hold_valid;

endmodule

// File: tb/tb_paralelo_serie.sv
// Self-checking bench for paralelo_serie: directed scenarios plus a randomized
// run checked against a bit-queue reference model.
module tb_paralelo_serie;

    localparam int unsigned WIDTH      = 4;
    localparam bit          IDLE_LEVEL = 1'b0;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid;
    logic             shift_en;
    logic [WIDTH-1:0] parallel_in;
    logic             load_ready, serial_out, frame, busy, done;
    logic             l_load_ready, l_serial_out, l_frame, l_busy, l_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    paralelo_serie #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
        .load_ready(load_ready), .shift_en(shift_en), .serial_out(serial_out),
        .frame(frame), .busy(busy), .done(done)
    );

    paralelo_serie #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_LEVEL)) dut_lsb (
        .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
        .load_ready(l_load_ready), .shift_en(shift_en), .serial_out(l_serial_out),
        .frame(l_frame), .busy(l_busy), .done(l_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [WIDTH-1:0] pin, input logic se);
        load_valid  = lv;
        parallel_in = pin;
        shift_en    = se;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({serial_out, frame, busy, load_ready, done} !== {IDLE_LEVEL, 4'b0010}) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got {ser,frame,busy,rdy,done}=%b expected %b",
                         i, {serial_out, frame, busy, load_ready, done}, {IDLE_LEVEL, 4'b0010});
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [3:0] w;
        w = 4'b1011;
        do_reset();
        drive(1'b1, w, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        n_checks++;
        if ({load_ready, frame, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_accept: got {rdy,frame,busy}=%b expected 001", {load_ready, frame, busy});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({frame, serial_out, done} !== {1'b1, w[3-k], 1'b0}) begin
                n_fail++;
                $display("FAIL single_bit%0d: got {frame,ser,done}=%b expected %b",
                         k, {frame, serial_out, done}, {1'b1, w[3-k], 1'b0});
            end
        end
        tick();
        n_checks++;
        if ({frame, serial_out, done} !== {1'b0, IDLE_LEVEL, 1'b1}) begin
            n_fail++;
            $display("FAIL single_end: got {frame,ser,done}=%b expected %b",
                     {frame, serial_out, done}, {1'b0, IDLE_LEVEL, 1'b1});
        end
        tick();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: got {done,busy}=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        logic       e_ser, e_frame, e_done, e_rdy;
        w = {4'hA, 4'h5};
        do_reset();
        drive(1'b1, 4'hA, 1'b1);
        tick();
        drive(1'b1, 4'h5, 1'b1);
        for (int s = 0; s < 10; s++) begin
            tick();
            if (s == 1) drive(1'b0, '0, 1'b1);
            e_frame = (s < 8);
            e_ser   = (s < 8) ? w[7-s] : IDLE_LEVEL;
            e_done  = (s == 4) || (s == 8);
            e_rdy   = !(s >= 1 && s <= 3);
            n_checks++;
            if ({frame, serial_out, done, load_ready} !== {e_frame, e_ser, e_done, e_rdy}) begin
                n_fail++;
                $display("FAIL b2b_s%0d: got {frame,ser,done,rdy}=%b expected %b",
                         s, {frame, serial_out, done, load_ready}, {e_frame, e_ser, e_done, e_rdy});
            end
        end
    endtask

    task automatic test_slow_strobe();
        logic [3:0] w;
        w = 4'b0110;
        do_reset();
        drive(1'b1, w, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        for (int k = 0; k <= 12; k++) begin
            n_checks++;
            if (k < 12) begin
                if ({frame, serial_out, done} !== {1'b1, w[3-k/3], 1'b0}) begin
                    n_fail++;
                    $display("FAIL slow_k%0d: got {frame,ser,done}=%b expected %b",
                             k, {frame, serial_out, done}, {1'b1, w[3-k/3], 1'b0});
                end
            end else if ({frame, done} !== 2'b01) begin
                n_fail++;
                $display("FAIL slow_end: got {frame,done}=%b expected 01", {frame, done});
            end
            shift_en = ((k % 3) == 2);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 4'hF, 1'b1);
        tick();
        drive(1'b1, 4'h3, 1'b1);
        tick();
        tick();
        drive(1'b0, '0, 1'b1);
        tick();
        n_checks++;
        if ({frame, busy, load_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL rmid_pre: got {frame,busy,rdy}=%b expected 110", {frame, busy, load_ready});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({serial_out, frame, busy, load_ready, done} !== {IDLE_LEVEL, 4'b0010}) begin
            n_fail++;
            $display("FAIL rmid_reset: got %b expected %b",
                     {serial_out, frame, busy, load_ready, done}, {IDLE_LEVEL, 4'b0010});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({serial_out, frame, busy, done} !== {IDLE_LEVEL, 3'b000}) begin
                n_fail++;
                $display("FAIL rmid_after%0d: got {ser,frame,busy,done}=%b expected %b",
                         i, {serial_out, frame, busy, done}, {IDLE_LEVEL, 3'b000});
            end
        end
    endtask

    task automatic test_lsb_loopback();
        logic [3:0] w;
        logic [3:0] rx;
        w  = 4'b0001;
        rx = '0;
        do_reset();
        drive(1'b1, w, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({l_frame, l_serial_out} !== {1'b1, w[k]}) begin
                n_fail++;
                $display("FAIL lsb_bit%0d: got {frame,ser}=%b expected %b",
                         k, {l_frame, l_serial_out}, {1'b1, w[k]});
            end
            rx = {l_serial_out, rx[3:1]};
        end
        n_checks++;
        if (rx !== w) begin
            n_fail++;
            $display("FAIL lsb_loopback: got %b expected %b", rx, w);
        end
        tick();
        n_checks++;
        if ({l_done, l_frame} !== 2'b10) begin
            n_fail++;
            $display("FAIL lsb_done: got {done,frame}=%b expected 10", {l_done, l_frame});
        end
    endtask

    // Reference: every accepted word appends its bits to a queue, each strobe
    // in frame consumes one; word boundaries every WIDTH consumed bits.
    task automatic test_random();
        logic             exp_q[$];
        logic             lv, se, acc, cons, last, gap_free, b;
        logic [WIDTH-1:0] pin;
        int               consumed;
        int               cyc;
        consumed = 0;
        do_reset();
        for (cyc = 0; cyc < 800; cyc++) begin
            if (cyc >= 600 && exp_q.size() == 0 && !frame) break;
            lv  = (cyc < 600) ? 1'($urandom % 2) : 1'b0;
            se  = (cyc < 600) ? ($urandom % 3 != 0) : 1'b1;
            pin = WIDTH'($urandom);
            drive(lv, pin, se);
            acc      = lv && load_ready;
            cons     = frame && se;
            last     = 1'b0;
            gap_free = 1'b0;
            if (cons) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_bit cyc%0d: got a data bit %b expected none", cyc, serial_out);
                end else begin
                    b = exp_q.pop_front();
                    if (serial_out !== b) begin
                        n_fail++;
                        $display("FAIL rand_bit cyc%0d: got %b expected %b", cyc, serial_out, b);
                    end
                end
                consumed++;
                last     = (consumed % WIDTH) == 0;
                gap_free = (exp_q.size() != 0);
            end
            if (acc) begin
                for (int i = 0; i < int'(WIDTH); i++) exp_q.push_back(pin[WIDTH-1-i]);
            end
            tick();
            n_checks++;
            if (done !== (cons && last)) begin
                n_fail++;
                $display("FAIL rand_done cyc%0d: got %b expected %b", cyc, done, cons && last);
            end
            if (cons && last) begin
                n_checks++;
                if (frame !== gap_free) begin
                    n_fail++;
                    $display("FAIL rand_gap cyc%0d: got frame %b expected %b", cyc, frame, gap_free);
                end
            end
            if (!frame) begin
                n_checks++;
                if (serial_out !== IDLE_LEVEL) begin
                    n_fail++;
                    $display("FAIL rand_idle cyc%0d: got %b expected %b", cyc, serial_out, IDLE_LEVEL);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || frame !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d bits left, frame %b expected 0 bits, frame 0",
                     exp_q.size(), frame);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        test_reset();
        test_single();
        test_back_to_back();
        test_slow_strobe();
        test_reset_mid();
        test_lsb_loopback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
